// File: rtl/voter_registry_ram.sv
// Voter registry: records each verified voter once, counts votes, supports audit
// reads and a swept, one-entry-per-cycle registry clear.
module voter_registry_ram #(
  parameter int unsigned WORD_SIZE    = 5,
  parameter int unsigned ADDRESS_SIZE = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    voter_id_status,
  input  logic                    write,
  input  logic [ADDRESS_SIZE-1:0] valid_voter_address,
  input  logic [WORD_SIZE-1:0]    valid_voter,
  input  logic                    clear_req,
  input  logic                    rd_en,
  input  logic [ADDRESS_SIZE-1:0] rd_addr,
  output logic                    busy,
  output logic                    vote_grant,
  output logic                    dup_voter,
  output logic [ADDRESS_SIZE:0]   vote_count,
  output logic                    all_voted,
  output logic                    clear_done,
  output logic                    rd_valid,
  output logic [WORD_SIZE-1:0]    rd_data,
  output logic                    rd_voted
);

  localparam int unsigned N  = 1 << ADDRESS_SIZE;
  localparam int unsigned CW = ADDRESS_SIZE + 1;
  localparam logic [CW-1:0]           FULL     = CW'(N);
  localparam logic [ADDRESS_SIZE-1:0] LAST_PTR = ADDRESS_SIZE'(N - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    COMMIT = 2'd2,
    CLEAR  = 2'd3
  } state_t;

  state_t                  state, state_d;
  logic [ADDRESS_SIZE-1:0] lat_addr, lat_addr_d;
  logic [WORD_SIZE-1:0]    lat_id, lat_id_d;
  logic [ADDRESS_SIZE-1:0] ptr, ptr_d;
  logic [N-1:0]            flags, flags_d;
  logic [CW-1:0]           count_d;
  logic                    busy_d, grant_d, dup_d, done_d, all_voted_d;
  logic                    commit_c;
  logic [WORD_SIZE-1:0]    ids [N];

  // Next-state, datapath updates and next values of the pulse outputs
  always_comb begin
    state_d    = state;
    lat_addr_d = lat_addr;
    lat_id_d   = lat_id;
    ptr_d      = ptr;
    flags_d    = flags;
    count_d    = vote_count;
    grant_d    = 1'b0;
    dup_d      = 1'b0;
    done_d     = 1'b0;
    commit_c   = 1'b0;

    case (state)
      IDLE: begin
        if (clear_req) begin
          state_d = CLEAR;
          count_d = '0;
          ptr_d   = '0;
        end else if (write && voter_id_status) begin
          state_d    = CHECK;
          lat_addr_d = valid_voter_address;
          lat_id_d   = valid_voter;
        end
      end
      CHECK: begin
        if (flags[lat_addr]) begin
          dup_d   = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        commit_c          = 1'b1;
        flags_d[lat_addr] = 1'b1;
        if (vote_count != FULL) count_d = vote_count + CW'(1);
        grant_d = 1'b1;
        state_d = IDLE;
      end
      CLEAR: begin
        flags_d[ptr] = 1'b0;
        ptr_d        = ptr + ADDRESS_SIZE'(1);
        if (ptr == LAST_PTR) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d      = (state_d != IDLE);
    all_voted_d = (count_d == FULL);
  end

  // Control state, flags and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      lat_addr   <= '0;
      lat_id     <= '0;
      ptr        <= '0;
      flags      <= '0;
      vote_count <= '0;
      busy       <= 1'b0;
      vote_grant <= 1'b0;
      dup_voter  <= 1'b0;
      clear_done <= 1'b0;
      all_voted  <= 1'b0;
    end else begin
      state      <= state_d;
      lat_addr   <= lat_addr_d;
      lat_id     <= lat_id_d;
      ptr        <= ptr_d;
      flags      <= flags_d;
      vote_count <= count_d;
      busy       <= busy_d;
      vote_grant <= grant_d;
      dup_voter  <= dup_d;
      clear_done <= done_d;
      all_voted  <= all_voted_d;
    end
  end

  // ID storage is not reset; the voted flags qualify its contents
  always_ff @(posedge clk) begin
    if (!rst && commit_c) ids[lat_addr] <= lat_id;
  end

  // Audit read sees pre-edge flags/IDs, so a same-cycle commit returns old data
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_voted <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data  <= flags[rd_addr] ? ids[rd_addr] : '0;
        rd_voted <= flags[rd_addr];
      end
    end
  end

endmodule

// File: tb/tb_voter_registry_ram.sv
// Randomized scoreboard bench for voter_registry_ram against an array-based registry model.
module tb_voter_registry_ram;

  logic       clk = 1'b0;
  logic       rst;
  logic       voter_id_status, write, clear_req, rd_en;
  logic [3:0] valid_voter_address, rd_addr;
  logic [4:0] valid_voter;
  logic       busy, vote_grant, dup_voter, all_voted, clear_done, rd_valid, rd_voted;
  logic [4:0] vote_count;
  logic [4:0] rd_data;

  voter_registry_ram #(.WORD_SIZE(5), .ADDRESS_SIZE(4)) dut (
    .clk(clk), .rst(rst),
    .voter_id_status(voter_id_status), .write(write),
    .valid_voter_address(valid_voter_address), .valid_voter(valid_voter),
    .clear_req(clear_req), .rd_en(rd_en), .rd_addr(rd_addr),
    .busy(busy), .vote_grant(vote_grant), .dup_voter(dup_voter),
    .vote_count(vote_count), .all_voted(all_voted), .clear_done(clear_done),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_voted(rd_voted)
  );

  always #5 clk = ~clk;

  // kind is one-hot {grant, dup, done}
  typedef struct { logic [2:0] kind; int cnt; } ev_t;
  typedef struct { logic [4:0] data; logic voted; } rd_t;

  ev_t ev_q[$];
  rd_t rd_q[$];

  bit         m_voted [16];
  logic [4:0] m_id    [16];
  int         m_cnt;

  int vectors = 0;
  int miscompares = 0;
  bit started = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    write = 1'b0; voter_id_status = 1'b0; clear_req = 1'b0; rd_en = 1'b0;
  endtask

  // Inputs that must be ignored while the block is busy
  task automatic garbage();
    write = 1'($urandom); clear_req = 1'($urandom); voter_id_status = 1'($urandom);
    valid_voter_address = 4'($urandom); valid_voter = 5'($urandom);
  endtask

  task automatic check_state();
    check("busy_idle", 32'(busy), 32'd0);
    check("vote_count", 32'(vote_count), 32'(m_cnt));
    check("all_voted", 32'(all_voted), 32'(m_cnt == 16));
  endtask

  task automatic do_write(input logic [3:0] a, input logic [4:0] id);
    ev_t e; rd_t r; int cyc; bit was;
    was = m_voted[a];
    r.voted = was; r.data = was ? m_id[a] : 5'd0;
    if (was) begin e.kind = 3'b010; e.cnt = m_cnt; end
    else     begin e.kind = 3'b100; e.cnt = m_cnt + 1; end
    ev_q.push_back(e);
    write = 1'b1; voter_id_status = 1'b1; clear_req = 1'b0; rd_en = 1'b0;
    valid_voter_address = a; valid_voter = id;
    cyc = 0;
    @(negedge clk);
    while (busy && cyc < 40) begin
      cyc++;
      garbage();
      rd_en = 1'b1; rd_addr = a; rd_q.push_back(r);
      @(negedge clk);
    end
    idle_inputs();
    check("write_busy_cycles", 32'(cyc), was ? 32'd1 : 32'd2);
    if (!was) begin m_voted[a] = 1'b1; m_id[a] = id; m_cnt++; end
  endtask

  task automatic do_read(input logic [3:0] a);
    rd_t r;
    r.voted = m_voted[a]; r.data = m_voted[a] ? m_id[a] : 5'd0;
    rd_q.push_back(r);
    rd_en = 1'b1; rd_addr = a;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic do_invalid();
    write = 1'b1; voter_id_status = 1'b0;
    valid_voter_address = 4'($urandom); valid_voter = 5'($urandom);
    repeat (3) begin
      @(negedge clk);
      check("invalid_write_busy", 32'(busy), 32'd0);
    end
    idle_inputs();
  endtask

  // abort_at = 0 runs a full sweep; otherwise rst is raised on that busy cycle
  task automatic do_clear(input int abort_at);
    ev_t e; rd_t r; int cyc; logic [3:0] ra;
    if (abort_at == 0) begin e.kind = 3'b001; e.cnt = 0; ev_q.push_back(e); end
    clear_req = 1'b1; write = 1'b1; voter_id_status = 1'b1; rd_en = 1'b0;
    valid_voter_address = 4'($urandom); valid_voter = 5'($urandom);
    cyc = 0;
    @(negedge clk);
    while (busy && cyc < 40) begin
      cyc++;
      if (cyc == abort_at) begin
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        break;
      end
      garbage();
      ra = 4'($urandom);
      if (int'(ra) < cyc - 1) begin r.voted = 1'b0; r.data = 5'd0; end
      else begin r.voted = m_voted[ra]; r.data = m_voted[ra] ? m_id[ra] : 5'd0; end
      rd_en = 1'b1; rd_addr = ra; rd_q.push_back(r);
      @(negedge clk);
    end
    idle_inputs();
    if (abort_at == 0) check("clear_busy_cycles", 32'(cyc), 32'd16);
    else               check("abort_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 16; i++) m_voted[i] = 1'b0;
    m_cnt = 0;
    check_state();
  endtask

  // Monitor: pops the expected response whenever the DUT presents one
  initial begin
    ev_t e; rd_t r;
    forever begin
      @(negedge clk);
      if (started) begin
        if (vote_grant || dup_voter || clear_done) begin
          if (ev_q.size() == 0) begin
            check("unexpected_pulse", 32'({vote_grant, dup_voter, clear_done}), 32'd0);
          end else begin
            e = ev_q.pop_front();
            check("pulse_kind", 32'({vote_grant, dup_voter, clear_done}), 32'(e.kind));
            check("pulse_vote_count", 32'(vote_count), 32'(e.cnt));
            check("pulse_all_voted", 32'(all_voted), 32'(e.cnt == 16));
          end
        end
        if (rd_valid) begin
          if (rd_q.size() == 0) begin
            check("unexpected_rd_valid", 32'(rd_valid), 32'd0);
          end else begin
            r = rd_q.pop_front();
            check("rd_data", 32'(rd_data), 32'(r.data));
            check("rd_voted", 32'(rd_voted), 32'(r.voted));
          end
        end
      end
    end
  end

  initial begin
    int order[16];
    int op;
    rst = 1'b1;
    idle_inputs();
    valid_voter_address = '0; valid_voter = '0; rd_addr = '0;
    for (int i = 0; i < 16; i++) begin m_voted[i] = 1'b0; m_id[i] = '0; end
    m_cnt = 0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_vote_count", 32'(vote_count), 32'd0);
    check("rst_pulses", 32'({vote_grant, dup_voter, clear_done, rd_valid}), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    rst = 1'b0;
    started = 1'b1;
    @(negedge clk);
    check_state();
    do_read(4'd3);

    do_write(4'd5, 5'b00101);
    do_read(4'd5);
    check_state();
    do_write(4'd5, 5'b00101);
    check_state();
    do_invalid();
    check_state();

    for (int i = 0; i < 16; i++) order[i] = i;
    for (int i = 15; i > 0; i--) begin
      int j, t;
      j = $urandom_range(0, i);
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
    for (int i = 0; i < 16; i++) do_write(4'(order[i]), 5'($urandom));
    check_state();
    do_write(4'($urandom), 5'($urandom));
    check_state();
    for (int i = 0; i < 16; i++) do_read(4'(i));

    do_clear(0);
    for (int i = 0; i < 16; i++) do_read(4'(i));

    for (int n = 0; n < 150; n++) begin
      op = $urandom_range(0, 9);
      if (op <= 4) do_write(4'($urandom), 5'($urandom));
      else if (op <= 6) do_read(4'($urandom));
      else if (op == 7) do_invalid();
      else if (op == 8 && $urandom_range(0, 3) == 0) do_clear(0);
      else check_state();
    end

    for (int i = 0; i < 10; i++) do_write(4'($urandom), 5'($urandom));
    do_clear($urandom_range(3, 14));
    for (int i = 0; i < 16; i++) do_read(4'(i));
    do_write(4'd9, 5'd17);
    do_read(4'd9);
    check_state();

    repeat (3) @(negedge clk);
    check("pending_events", 32'(ev_q.size()), 32'd0);
    check("pending_reads", 32'(rd_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
